// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

   typedef enum logic {
      WR_PASS = 1'b0,
      WR_DROP = 1'b1
   } wr_state_t;

   // Pointers are aw+1 bits wide; full means wr leads rd by exactly 2**aw modulo 2**(aw+1).
   function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                     input int unsigned aw);
      logic [31:0] w_mask;
      w_mask = (32'd1 << (aw + 32'd1)) - 32'd1;
      return ((wr - rd) & w_mask) == (32'd1 << aw);
   endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module axis_pkt_fifo_ram
   import axis_pkt_fifo_pkg::*;
#(
   parameter int WIDTH = 37,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [WIDTH-1:0]         o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with store-and-forward frame mode (drop bad/oversized frames)
// or cut-through mode; single clock, synchronous active-high reset.
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int DEPTH          = 512,
   parameter int FRAME_MODE     = 1,
   parameter int DROP_BAD_FRAME = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tuser,
   output logic                       s_axis_tready,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     status_occupancy,
   output logic                       status_good_frame,
   output logic                       status_drop_bad,
   output logic                       status_drop_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]   r_wr_ptr_cur;
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   r_rd_addr;
   wr_state_t     r_state;
   logic          r_good;
   logic          r_drop_bad;
   logic          r_drop_ovf;
   logic          r_ram_vld;
   logic          r_m_valid;
   logic          r_skid_vld;
   logic [WW-1:0] r_m_word;
   logic [WW-1:0] r_skid_word;

   logic          w_full;
   logic          w_s_ready;
   logic          w_s_hs;
   logic          w_wr_en;
   logic          w_pop;
   logic          w_rd_en;
   logic [1:0]    w_inflight;
   logic [WW-1:0] w_wr_word;
   logic [WW-1:0] w_ram_q;

   // rd_ptr advances only on an output handshake, so prefetched words still count as stored.
   assign w_full    = ptr_full(32'(r_wr_ptr_cur), 32'(r_rd_ptr), AW);
   assign w_s_ready = (FRAME_MODE != 0) ? !rst : (!rst && !w_full);
   assign w_s_hs    = s_axis_tvalid && w_s_ready;
   assign w_wr_en   = w_s_hs && !w_full && (r_state == WR_PASS);
   assign w_wr_word = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   assign w_pop      = r_m_valid && m_axis_tready;
   assign w_inflight = 2'(r_m_valid) + 2'(r_skid_vld) + 2'(r_ram_vld);
   assign w_rd_en    = (r_wr_ptr != r_rd_addr) &&
                       ((w_inflight <= 2'd1) || ((w_inflight == 2'd2) && w_pop));

   axis_pkt_fifo_ram #(
      .WIDTH (WW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr_cur[AW-1:0]),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_addr[AW-1:0]),
      .o_rd_data (w_ram_q)
   );

   // Write FSM: speculative pointer runs ahead, committed pointer moves only on good tlast.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr_cur <= '0;
         r_wr_ptr     <= '0;
         r_state      <= WR_PASS;
         r_good       <= 1'b0;
         r_drop_bad   <= 1'b0;
         r_drop_ovf   <= 1'b0;
      end else begin
         r_good     <= 1'b0;
         r_drop_bad <= 1'b0;
         r_drop_ovf <= 1'b0;
         if (w_wr_en) r_wr_ptr_cur <= r_wr_ptr_cur + PTR_ONE;
         if (FRAME_MODE == 0) begin
            if (w_wr_en) begin
               r_wr_ptr <= r_wr_ptr_cur + PTR_ONE;
               r_good   <= s_axis_tlast;
            end
         end else if (w_s_hs) begin
            case (r_state)
               WR_PASS: begin
                  if (w_full) begin
                     r_wr_ptr_cur <= r_wr_ptr;
                     if (s_axis_tlast) r_drop_ovf <= 1'b1;
                     else              r_state    <= WR_DROP;
                  end else if (s_axis_tlast) begin
                     if (s_axis_tuser && (DROP_BAD_FRAME != 0)) begin
                        r_wr_ptr_cur <= r_wr_ptr;
                        r_drop_bad   <= 1'b1;
                     end else begin
                        r_wr_ptr <= r_wr_ptr_cur + PTR_ONE;
                        r_good   <= 1'b1;
                     end
                  end
               end
               WR_DROP: begin
                  if (s_axis_tlast) begin
                     r_drop_ovf <= 1'b1;
                     r_state    <= WR_PASS;
                  end
               end
               default: r_state <= WR_PASS;
            endcase
         end
      end
   end

   // Read pipeline: RAM read stage feeding a two-entry output register plus skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_addr   <= '0;
         r_rd_ptr    <= '0;
         r_ram_vld   <= 1'b0;
         r_m_valid   <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_m_word    <= '0;
         r_skid_word <= '0;
      end else begin
         r_ram_vld <= w_rd_en;
         if (w_rd_en) r_rd_addr <= r_rd_addr + PTR_ONE;
         if (w_pop)   r_rd_ptr  <= r_rd_ptr + PTR_ONE;
         if (!r_m_valid || w_pop) begin
            if (r_skid_vld) begin
               r_m_word   <= r_skid_word;
               r_m_valid  <= 1'b1;
               r_skid_vld <= r_ram_vld;
               if (r_ram_vld) r_skid_word <= w_ram_q;
            end else begin
               r_m_valid <= r_ram_vld;
               if (r_ram_vld) r_m_word <= w_ram_q;
            end
         end else if (r_ram_vld) begin
            r_skid_vld  <= 1'b1;
            r_skid_word <= w_ram_q;
         end
      end
   end

   assign s_axis_tready        = w_s_ready;
   assign m_axis_tvalid        = r_m_valid;
   assign m_axis_tdata         = r_m_word[DATA_WIDTH-1:0];
   assign m_axis_tkeep         = r_m_word[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis_tlast         = r_m_word[WW-1];
   assign status_occupancy     = r_wr_ptr_cur - r_rd_ptr;
   assign status_good_frame    = r_good;
   assign status_drop_bad      = r_drop_bad;
   assign status_drop_overflow = r_drop_ovf;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: a DEPTH=16 frame-mode instance and a DEPTH=8 cut-through instance.
module tb_axis_pkt_fifo;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] fSData;
   logic [3:0]  fSKeep;
   logic        fSValid, fSLast, fSUser, fSReady;
   logic [31:0] fMData;
   logic [3:0]  fMKeep;
   logic        fMValid, fMLast, fMReady;
   logic [4:0]  fOcc;
   logic        fGood, fDropBad, fDropOvf;

   logic [31:0] cSData;
   logic [3:0]  cSKeep;
   logic        cSValid, cSLast, cSUser, cSReady;
   logic [31:0] cMData;
   logic [3:0]  cMKeep;
   logic        cMValid, cMLast, cMReady;
   logic [3:0]  cOcc;
   logic        cGood, cDropBad, cDropOvf;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int fGoodCnt = 0, fBadCnt = 0, fOvfCnt = 0;
   int cGoodCnt = 0, cDropCnt = 0;
   int snapGood, snapBad, snapOvf, snapCGood, snapCDrop, span;
   logic        readyLowSeen;
   logic [36:0] fOut[$];
   logic [36:0] fExp[$];
   logic [36:0] cOut[$];
   logic [36:0] cExp[$];
   int          fOutCyc[$];

   always #5 clk = ~clk;

   axis_pkt_fifo #(
      .DATA_WIDTH (32), .KEEP_WIDTH (4), .DEPTH (16), .FRAME_MODE (1), .DROP_BAD_FRAME (1)
   ) dutFrame (
      .clk (clk), .rst (rst),
      .s_axis_tdata (fSData), .s_axis_tkeep (fSKeep), .s_axis_tvalid (fSValid),
      .s_axis_tlast (fSLast), .s_axis_tuser (fSUser), .s_axis_tready (fSReady),
      .m_axis_tdata (fMData), .m_axis_tkeep (fMKeep), .m_axis_tvalid (fMValid),
      .m_axis_tlast (fMLast), .m_axis_tready (fMReady),
      .status_occupancy (fOcc), .status_good_frame (fGood),
      .status_drop_bad (fDropBad), .status_drop_overflow (fDropOvf)
   );

   axis_pkt_fifo #(
      .DATA_WIDTH (32), .KEEP_WIDTH (4), .DEPTH (8), .FRAME_MODE (0), .DROP_BAD_FRAME (1)
   ) dutCut (
      .clk (clk), .rst (rst),
      .s_axis_tdata (cSData), .s_axis_tkeep (cSKeep), .s_axis_tvalid (cSValid),
      .s_axis_tlast (cSLast), .s_axis_tuser (cSUser), .s_axis_tready (cSReady),
      .m_axis_tdata (cMData), .m_axis_tkeep (cMKeep), .m_axis_tvalid (cMValid),
      .m_axis_tlast (cMLast), .m_axis_tready (cMReady),
      .status_occupancy (cOcc), .status_good_frame (cGood),
      .status_drop_bad (cDropBad), .status_drop_overflow (cDropOvf)
   );

   // Count cycles and log every output handshake and status pulse, sampled mid-cycle.
   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (fMValid && fMReady) begin
            fOut.push_back({fMLast, fMKeep, fMData});
            fOutCyc.push_back(cycle);
         end
         if (cMValid && cMReady) cOut.push_back({cMLast, cMKeep, cMData});
         if (fGood)    fGoodCnt <= fGoodCnt + 1;
         if (fDropBad) fBadCnt  <= fBadCnt + 1;
         if (fDropOvf) fOvfCnt  <= fOvfCnt + 1;
         if (cGood)    cGoodCnt <= cGoodCnt + 1;
         if (cDropBad || cDropOvf) cDropCnt <= cDropCnt + 1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, want finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [36:0] mkWord(input logic last, input logic [3:0] keep,
                                          input logic [31:0] data);
      return {last, keep, data};
   endfunction

   function automatic logic [3:0] keepOf(input int i);
      case (i % 4)
         0:       return 4'hF;
         1:       return 4'h1;
         2:       return 4'h3;
         default: return 4'h7;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat to the chosen instance and hold it until accepted (bounded wait).
   task automatic applyStimulus(input bit toCut, input logic [31:0] data, input logic [3:0] keep,
                                input logic last, input logic user);
      int waited = 0;
      if (toCut) begin
         cSData = data; cSKeep = keep; cSLast = last; cSUser = user; cSValid = 1'b1;
         while (!cSReady && waited < 50) begin
            tick();
            waited++;
         end
      end else begin
         fSData = data; fSKeep = keep; fSLast = last; fSUser = user; fSValid = 1'b1;
         while (!fSReady && waited < 50) begin
            tick();
            waited++;
         end
      end
      if (waited > 0) readyLowSeen = 1'b1;
      if (waited >= 50) checkOutput(toCut ? "cSendTimeout" : "fSendTimeout", 64'(waited), 64'd0);
      tick();
      cSValid = 1'b0;
      fSValid = 1'b0;
   endtask

   task automatic sendFrameF(input int n, input logic [31:0] base, input logic badLast);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, base + 32'(i), 4'hF, (i == n - 1), badLast && (i == n - 1));
   endtask

   // Wait for the expected number of output beats, allow a few extra cycles, then compare.
   task automatic checkDrain(input bit isCut, input string tag);
      int waited = 0;
      int nOut;
      int nExp;
      nExp = isCut ? cExp.size() : fExp.size();
      while ((isCut ? cOut.size() : fOut.size()) < nExp && waited < 300) begin
         tick();
         waited++;
      end
      tick(6);
      nOut = isCut ? cOut.size() : fOut.size();
      checkOutput({tag, "_count"}, 64'(nOut), 64'(nExp));
      for (int i = 0; i < nExp && i < nOut; i++)
         checkOutput($sformatf("%s_beat%0d", tag, i),
                     64'(isCut ? cOut[i] : fOut[i]), 64'(isCut ? cExp[i] : fExp[i]));
      if (isCut) begin
         cOut.delete();
         cExp.delete();
      end else begin
         fOut.delete();
         fExp.delete();
         fOutCyc.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      fSData = '0; fSKeep = '0; fSValid = 1'b0; fSLast = 1'b0; fSUser = 1'b0;
      cSData = '0; cSKeep = '0; cSValid = 1'b0; cSLast = 1'b0; cSUser = 1'b0;
      fMReady = 1'b0; cMReady = 1'b0; readyLowSeen = 1'b0;
      tick(3);

      checkOutput("rstFReady", 64'(fSReady), 64'd0);
      checkOutput("rstFValid", 64'(fMValid), 64'd0);
      checkOutput("rstFData",  64'(fMData),  64'd0);
      checkOutput("rstFKeep",  64'(fMKeep),  64'd0);
      checkOutput("rstFLast",  64'(fMLast),  64'd0);
      checkOutput("rstFOcc",   64'(fOcc),    64'd0);
      checkOutput("rstFPulse", 64'({fGood, fDropBad, fDropOvf}), 64'd0);
      checkOutput("rstCReady", 64'(cSReady), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("postRstFReady", 64'(fSReady), 64'd1);
      checkOutput("postRstCReady", 64'(cSReady), 64'd1);

      $display("[TB] cut-through: fill DEPTH=8 with reader stalled");
      snapCGood = cGoodCnt; snapCDrop = cDropCnt;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'h50 + 32'(i), keepOf(i), 1'b0, 1'b0);
         if (i == 0) checkOutput("ctLatBeat0", 64'(cMValid), 64'd0);
         if (i == 2) begin
            checkOutput("ctLatValid", 64'(cMValid), 64'd1);
            checkOutput("ctLatData",  64'(cMData),  64'h50);
         end
      end
      checkOutput("ctFullReady", 64'(cSReady), 64'd0);
      checkOutput("ctFullOcc",   64'(cOcc),    64'd8);
      cMReady = 1'b1;
      applyStimulus(1'b1, 32'h58, keepOf(8), 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h59, keepOf(9), 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cExp.push_back(mkWord(i == 9, keepOf(i), 32'h50 + 32'(i)));
      checkDrain(1'b1, "ct");
      checkOutput("ctGoodPulses", 64'(cGoodCnt - snapCGood), 64'd1);
      checkOutput("ctDropPulses", 64'(cDropCnt - snapCDrop), 64'd0);
      checkOutput("ctOccEmpty",   64'(cOcc), 64'd0);

      $display("[TB] frame mode: 4-beat good frame latency");
      fMReady = 1'b1;
      snapGood = fGoodCnt;
      sendFrameF(4, 32'hA0, 1'b0);
      checkOutput("frmPulseGood", 64'(fGood), 64'd1);
      checkOutput("frmLat0", 64'(fMValid), 64'd0);
      tick();
      checkOutput("frmLat1", 64'(fMValid), 64'd0);
      tick();
      checkOutput("frmLat2", 64'(fMValid), 64'd1);
      checkOutput("frmLat2Data", 64'(fMData), 64'hA0);
      for (int i = 0; i < 4; i++) fExp.push_back(mkWord(i == 3, 4'hF, 32'hA0 + 32'(i)));
      checkDrain(1'b0, "frmA");
      checkOutput("frmAGoodCnt", 64'(fGoodCnt - snapGood), 64'd1);

      $display("[TB] frame mode: bad frame then good frame");
      snapGood = fGoodCnt; snapBad = fBadCnt;
      sendFrameF(3, 32'hB0, 1'b1);
      sendFrameF(2, 32'hC0, 1'b0);
      fExp.push_back(mkWord(1'b0, 4'hF, 32'hC0));
      fExp.push_back(mkWord(1'b1, 4'hF, 32'hC1));
      checkDrain(1'b0, "frmB");
      checkOutput("frmBBadCnt",  64'(fBadCnt - snapBad),   64'd1);
      checkOutput("frmBGoodCnt", 64'(fGoodCnt - snapGood), 64'd1);
      checkOutput("frmBOcc",     64'(fOcc), 64'd0);

      $display("[TB] frame mode: exact-fit frame then oversized frame");
      fMReady = 1'b0; readyLowSeen = 1'b0;
      snapGood = fGoodCnt; snapBad = fBadCnt; snapOvf = fOvfCnt;
      sendFrameF(16, 32'hD00, 1'b0);
      sendFrameF(17, 32'hE00, 1'b0);
      tick(3);
      checkOutput("ovfReadyHeld", 64'(readyLowSeen), 64'd0);
      checkOutput("ovfOvfCnt",  64'(fOvfCnt - snapOvf),   64'd1);
      checkOutput("ovfGoodCnt", 64'(fGoodCnt - snapGood), 64'd1);
      checkOutput("ovfBadCnt",  64'(fBadCnt - snapBad),   64'd0);
      checkOutput("ovfOcc",     64'(fOcc),   64'd16);
      checkOutput("ovfHoldValid", 64'(fMValid), 64'd1);
      checkOutput("ovfHoldData",  64'(fMData),  64'hD00);
      fMReady = 1'b1;
      for (int i = 0; i < 16; i++) fExp.push_back(mkWord(i == 15, 4'hF, 32'hD00 + 32'(i)));
      checkDrain(1'b0, "ovf");
      checkOutput("ovfOccEmpty", 64'(fOcc), 64'd0);

      $display("[TB] frame mode: 1-beat frames with random reader stalls");
      fork
         begin
            for (int i = 0; i < 12; i++) sendFrameF(1, 32'h100 + 32'(i), 1'b0);
         end
         begin
            for (int k = 0; k < 30; k++) begin
               fMReady = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      fMReady = 1'b1;
      for (int i = 0; i < 12; i++) fExp.push_back(mkWord(1'b1, 4'hF, 32'h100 + 32'(i)));
      checkDrain(1'b0, "rnd");

      $display("[TB] frame mode: back-to-back throughput");
      for (int i = 0; i < 8; i++) sendFrameF(1, 32'h200 + 32'(i), 1'b0);
      tick(8);
      span = (fOutCyc.size() >= 8) ? (fOutCyc[7] - fOutCyc[0]) : -1;
      checkOutput("thrSpan", 64'(span), 64'd7);
      for (int i = 0; i < 8; i++) fExp.push_back(mkWord(1'b1, 4'hF, 32'h200 + 32'(i)));
      checkDrain(1'b0, "thr");

      $display("[TB] frame mode: reset with a partial frame stored");
      fMReady = 1'b0;
      sendFrameF(2, 32'h400, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h402 + 32'(i), 4'hF, 1'b0, 1'b0);
      checkOutput("midOcc",   64'(fOcc),    64'd5);
      checkOutput("midValid", 64'(fMValid), 64'd1);
      rst = 1'b1;
      tick();
      checkOutput("midRstValid", 64'(fMValid), 64'd0);
      checkOutput("midRstData",  64'(fMData),  64'd0);
      checkOutput("midRstKeep",  64'(fMKeep),  64'd0);
      checkOutput("midRstLast",  64'(fMLast),  64'd0);
      checkOutput("midRstOcc",   64'(fOcc),    64'd0);
      checkOutput("midRstReady", 64'(fSReady), 64'd0);
      rst = 1'b0;
      #1;
      fMReady = 1'b1;
      sendFrameF(2, 32'h300, 1'b0);
      fExp.push_back(mkWord(1'b0, 4'hF, 32'h300));
      fExp.push_back(mkWord(1'b1, 4'hF, 32'h301));
      checkDrain(1'b0, "postRst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
